// File: rtl/dsm_top_core.sv
// dsm_top_core -- second-order, single-bit delta-sigma modulator.
// Converts a 20-bit signed PCM stream into a +/-FS pulse-density bit that
// drives a 1-bit DAC. One modulator update on every rising clock edge.
// The two 26-bit integrators saturate instead of wrapping, so an
// over-range input degrades the output density but cannot flip its sign.
// Build option: define DSM_DITHER_EN to add a 16-bit Galois LFSR.
// Its top 13 bits, sign-extended to +/-4096, are added at the quantizer
// input only.
module dsm_top_core (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] vin,
    output logic        pwm
);

    // Integrator limits: the full 26-bit signed range.
    localparam logic [25:0] I_MAX  = 26'h1FF_FFFF;
    localparam logic [25:0] I_MIN  = 26'h200_0000;
    // Feedback levels +2^19 and -2^19, already sign-extended to 26 bits.
    localparam logic [25:0] FB_POS = 26'h008_0000;
    localparam logic [25:0] FB_NEG = 26'h3F8_0000;

    logic [19:0] x_r;
    logic [25:0] i1;
    logic [25:0] i2;
    logic [25:0] fb;
    logic [27:0] sum1;
    logic [27:0] sum2;
    logic [25:0] i1_next;
    logic [25:0] i2_next;

    // Clamp a 28-bit signed sum into the 26-bit integrator range.
    function automatic logic [25:0] sat26(input logic [27:0] s);
        logic signed [27:0] ss;
        ss = $signed(s);
        if (ss > 28'sd33554431) begin
            return I_MAX;
        end else if (ss < -28'sd33554432) begin
            return I_MIN;
        end else begin
            return s[25:0];
        end
    endfunction

`ifdef DSM_DITHER_EN
    logic [15:0] lfsr;
    logic [26:0] q;

    // Dithered quantizer input. The extra bit keeps i2 + d from wrapping
    // when i2 sits at a rail.
    assign q   = {i2[25], i2} + {{14{lfsr[15]}}, lfsr[15:3]};
    assign pwm = ~q[26];

    // Galois LFSR for x^16+x^14+x^13+x^11+1, right-shifting; it steps on every non-reset edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    // Plain quantizer: the output bit is 1 while i2 >= 0.
    assign pwm = ~i2[25];
`endif

    // The feedback level follows the current output bit.
    assign fb = pwm ? FB_POS : FB_NEG;

    // Integrator sums are formed at 28 bits so they never wrap before they are clamped.
    assign sum1 = {{8{x_r[19]}}, x_r} + {{2{i1[25]}}, i1} - {{2{fb[25]}}, fb};
    assign sum2 = {{2{i2[25]}}, i2} + {{2{i1[25]}}, i1} - {fb[25], fb, 1'b0};

    assign i1_next = sat26(sum1);
    assign i2_next = sat26(sum2);

    // Input register and both integrators. Reset is synchronous and wins over any vin activity.
    always_ff @(posedge clock) begin
        if (!reset) begin
            x_r <= '0;
            i1  <= '0;
            i2  <= '0;
        end else begin
            // NOTE: non-blocking assignments mean that i2 sees the pre-update i1, as the loop requires.
            x_r <= vin;
            i1  <= i1_next;
            i2  <= i2_next;
        end
    end

endmodule

// File: tb/tb_dsm_top_core.sv
// tb_dsm_top_core -- self-checking bench for the default (undithered) build
// of dsm_top_core. A reference model built on plain integers follows the
// modulator equations. Each scenario task checks the DUT bit for bit against
// that model and also checks the properties a listener cares about:
// density, latency and reset behaviour.
module tb_dsm_top_core;

    localparam longint FS    = 524288;
    localparam longint I_MAX = 33554431;
    localparam longint I_MIN = -33554432;

    logic        clock;
    logic        reset;
    logic [19:0] vin;
    logic        pwm;

    dsm_top_core dut (
        .clock (clock),
        .reset (reset),
        .vin   (vin),
        .pwm   (pwm)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        longint xr;
        longint i1;
        longint i2;
    } mstate_t;

    int      n_pass;
    int      n_total;
    mstate_t m;
    int      step_err;
    int      first_err_cyc;
    int      cyc;

    function automatic longint clamp(input longint v);
        if (v > I_MAX) return I_MAX;
        if (v < I_MIN) return I_MIN;
        return v;
    endfunction

    function automatic bit model_bit(input mstate_t s);
        return s.i2 >= 0;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input bit rst_n, input longint v);
        mstate_t n;
        longint  fb;
        if (!rst_n) begin
            n.xr = 0;
            n.i1 = 0;
            n.i2 = 0;
        end else begin
            fb   = model_bit(s) ? FS : -FS;
            n.xr = v;
            n.i1 = clamp(s.i1 + s.xr - fb);
            n.i2 = clamp(s.i2 + s.i1 - 2 * fb);
        end
        return n;
    endfunction

    function automatic int rand_vin();
        return int'($urandom_range(838860)) - 419430;
    endfunction

    // Run one clock. Inputs change 1 time unit after the edge. The model and DUT are compared there too.
    task automatic drive(input bit rst_n, input int v);
        logic [31:0] vb;
        vb    = v;
        reset = rst_n;
        vin   = vb[19:0];
        @(posedge clock);
        #1;
        cyc++;
        m = model_step(m, rst_n, longint'(v));
        if (pwm !== model_bit(m) || dut.x_r !== m.xr[19:0] ||
            dut.i1 !== m.i1[25:0] || dut.i2 !== m.i2[25:0]) begin
            if (step_err == 0) first_err_cyc = cyc;
            step_err++;
        end
    endtask

    task automatic test_reset();
        int          v1;
        int          v2;
        logic [31:0] v1b;
        logic [31:0] v2b;
        step_err = 0;
        for (int k = 0; k < 5; k++) drive(1'b0, rand_vin());
        n_total++;
        if (dut.x_r !== 20'd0) $display("FAIL reset_x_r: got %0d required 0", $signed(dut.x_r));
        else n_pass++;
        n_total++;
        if (dut.i1 !== 26'd0) $display("FAIL reset_i1: got %0d required 0", $signed(dut.i1));
        else n_pass++;
        n_total++;
        if (dut.i2 !== 26'd0) $display("FAIL reset_i2: got %0d required 0", $signed(dut.i2));
        else n_pass++;
        n_total++;
        if (pwm !== 1'b1) $display("FAIL reset_pwm: got %b required 1", pwm);
        else n_pass++;

        // First update: pwm=1 so fb=+FS; i1 = -FS, i2 = -2FS, x_r = v1.
        v1  = rand_vin();
        v1b = v1;
        drive(1'b1, v1);
        n_total++;
        if (dut.x_r !== v1b[19:0]) $display("FAIL first_x_r: got %0d required %0d", $signed(dut.x_r), v1);
        else n_pass++;
        n_total++;
        if ($signed(dut.i1) !== -26'sd524288) $display("FAIL first_i1: got %0d required -524288", $signed(dut.i1));
        else n_pass++;
        n_total++;
        if ($signed(dut.i2) !== -26'sd1048576) $display("FAIL first_i2: got %0d required -1048576", $signed(dut.i2));
        else n_pass++;
        n_total++;
        if (pwm !== 1'b0) $display("FAIL first_pwm: got %b required 0", pwm);
        else n_pass++;

        // Second update: fb=-FS; i1 = -FS + v1 + FS = v1, i2 = -2FS - FS + 2FS = -FS.
        v2  = rand_vin();
        v2b = v2;
        drive(1'b1, v2);
        n_total++;
        if (dut.i1 !== v1b[25:0]) $display("FAIL second_i1: got %0d required %0d", $signed(dut.i1), v1);
        else n_pass++;
        n_total++;
        if ($signed(dut.i2) !== -26'sd524288) $display("FAIL second_i2: got %0d required -524288", $signed(dut.i2));
        else n_pass++;
        n_total++;
        if (dut.x_r !== v2b[19:0]) $display("FAIL second_x_r: got %0d required %0d", $signed(dut.x_r), v2);
        else n_pass++;
        n_total++;
        if (step_err !== 0) $display("FAIL reset_model: %0d cycles differ, first at cycle %0d, required 0", step_err, first_err_cyc);
        else n_pass++;
    endtask

    task automatic test_idle();
        int ones;
        int run;
        int max_run;
        bit prev;
        step_err = 0;
        ones     = 0;
        run      = 0;
        max_run  = 0;
        prev     = 1'b0;
        drive(1'b0, 0);
        drive(1'b0, 0);
        for (int k = 0; k < 2000; k++) begin
            drive(1'b1, 0);
            if (k >= 1000 && pwm === 1'b1) ones++;
            if (k >= 10) begin
                run = (k > 10 && pwm === prev) ? run + 1 : 1;
                if (run > max_run) max_run = run;
            end
            prev = pwm;
        end
        n_total++;
        if (ones < 498 || ones > 502) $display("FAIL idle_density: got %0d ones in 1000 required 498..502", ones);
        else n_pass++;
        n_total++;
        if (max_run > 2) $display("FAIL idle_run_length: got run of %0d required <= 2", max_run);
        else n_pass++;
        n_total++;
        if (step_err !== 0) $display("FAIL idle_model: %0d cycles differ, first at cycle %0d, required 0", step_err, first_err_cyc);
        else n_pass++;
    endtask

    task automatic test_half_scale();
        int ones;
        int lo;
        int hi;
        int v;
        for (int s = 0; s < 2; s++) begin
            step_err = 0;
            ones     = 0;
            v        = (s == 0) ? 262144 : -262144;
            lo       = (s == 0) ? 2980 : 980;
            hi       = (s == 0) ? 3020 : 1020;
            drive(1'b0, 0);
            for (int k = 0; k < 200; k++) drive(1'b1, v);
            for (int k = 0; k < 4000; k++) begin
                drive(1'b1, v);
                if (pwm === 1'b1) ones++;
            end
            n_total++;
            if (ones < lo || ones > hi) $display("FAIL half_density vin=%0d: got %0d ones in 4000 required %0d..%0d", v, ones, lo, hi);
            else n_pass++;
            n_total++;
            if (step_err !== 0) $display("FAIL half_model vin=%0d: %0d cycles differ, first at cycle %0d, required 0", v, step_err, first_err_cyc);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int     ones;
        longint d_i2;
        longint max_i2;
        bit     hit_rail;
        bit     flipped;
        step_err = 0;
        ones     = 0;
        max_i2   = I_MIN;
        hit_rail = 1'b0;
        flipped  = 1'b0;
        drive(1'b0, 0);
        for (int k = 0; k < 20000; k++) begin
            drive(1'b1, 524287);
            if (pwm === 1'b1) ones++;
            d_i2 = longint'($signed(dut.i2));
            if (d_i2 > max_i2) max_i2 = d_i2;
            if (hit_rail && d_i2 < 0) flipped = 1'b1;
            if (d_i2 == I_MAX) hit_rail = 1'b1;
        end
        n_total++;
        if (max_i2 !== I_MAX) $display("FAIL sat_i2_rail: got max %0d required %0d", max_i2, I_MAX);
        else n_pass++;
        n_total++;
        if (flipped !== 1'b0) $display("FAIL sat_sign_flip: got flip=%b required 0", flipped);
        else n_pass++;
        n_total++;
        if (ones < 19600) $display("FAIL sat_density: got %0d ones in 20000 required >= 19600", ones);
        else n_pass++;

        ones = 0;
        for (int k = 0; k < 1200; k++) begin
            drive(1'b1, 0);
            if (k >= 200 && pwm === 1'b1) ones++;
        end
        n_total++;
        if (ones < 490 || ones > 510) $display("FAIL sat_recovery: got %0d ones in 1000 required 490..510", ones);
        else n_pass++;
        n_total++;
        if (step_err !== 0) $display("FAIL sat_model: %0d cycles differ, first at cycle %0d, required 0", step_err, first_err_cyc);
        else n_pass++;
    endtask

    task automatic test_latency();
        mstate_t alt;
        longint  diff;
        step_err = 0;
        drive(1'b0, 0);
        for (int k = 0; k < 100; k++) drive(1'b1, 0);
        alt = m;

        // Edge n: the step is only captured in x_r.
        drive(1'b1, 100000);
        alt = model_step(alt, 1'b1, 0);
        n_total++;
        if (dut.x_r !== 20'd100000) $display("FAIL lat_n_x_r: got %0d required 100000", $signed(dut.x_r));
        else n_pass++;
        n_total++;
        if (dut.i1 !== alt.i1[25:0]) $display("FAIL lat_n_i1: got %0d required %0d", $signed(dut.i1), alt.i1);
        else n_pass++;
        n_total++;
        if (pwm !== model_bit(alt)) $display("FAIL lat_n_pwm: got %b required %b", pwm, model_bit(alt));
        else n_pass++;

        // Edge n+1: i1 moves by exactly the step. i2 and pwm are still unaffected.
        drive(1'b1, 100000);
        alt  = model_step(alt, 1'b1, 0);
        diff = longint'($signed(dut.i1)) - alt.i1;
        n_total++;
        if (diff !== 100000) $display("FAIL lat_n1_i1: got delta %0d required 100000", diff);
        else n_pass++;
        n_total++;
        if (dut.i2 !== alt.i2[25:0]) $display("FAIL lat_n1_i2: got %0d required %0d", $signed(dut.i2), alt.i2);
        else n_pass++;
        n_total++;
        if (pwm !== model_bit(alt)) $display("FAIL lat_n1_pwm: got %b required %b", pwm, model_bit(alt));
        else n_pass++;

        // Edge n+2: i2 picks up the step.
        drive(1'b1, 100000);
        alt  = model_step(alt, 1'b1, 0);
        diff = longint'($signed(dut.i2)) - alt.i2;
        n_total++;
        if (diff !== 100000) $display("FAIL lat_n2_i2: got delta %0d required 100000", diff);
        else n_pass++;
        n_total++;
        if (step_err !== 0) $display("FAIL lat_model: %0d cycles differ, first at cycle %0d, required 0", step_err, first_err_cyc);
        else n_pass++;
    endtask

    task automatic test_midstream_reset();
        int seq [300];
        bit ref_bits [300];
        int diffs;
        step_err = 0;
        diffs    = 0;
        seq[0]   = 300000;
        for (int k = 1; k < 300; k++) seq[k] = rand_vin();
        drive(1'b0, 0);
        drive(1'b0, 0);
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, seq[k]);
            ref_bits[k] = pwm;
        end
        for (int k = 0; k < 400; k++) drive(1'b1, rand_vin());
        for (int k = 0; k < 20; k++) drive(1'b1, 300000);
        drive(1'b0, 300000);
        n_total++;
        if (dut.x_r !== 20'd0 || dut.i1 !== 26'd0 || dut.i2 !== 26'd0)
            $display("FAIL mid_reset_state: got x_r=%0d i1=%0d i2=%0d required 0 0 0",
                     $signed(dut.x_r), $signed(dut.i1), $signed(dut.i2));
        else n_pass++;
        n_total++;
        if (pwm !== 1'b1) $display("FAIL mid_reset_pwm: got %b required 1", pwm);
        else n_pass++;
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, seq[k]);
            if (pwm !== ref_bits[k]) diffs++;
        end
        n_total++;
        if (diffs !== 0) $display("FAIL mid_replay: got %0d differing bits vs fresh run required 0", diffs);
        else n_pass++;
        n_total++;
        if (step_err !== 0) $display("FAIL mid_model: %0d cycles differ, first at cycle %0d, required 0", step_err, first_err_cyc);
        else n_pass++;
    endtask

    task automatic test_random();
        int v;
        int len;
        step_err = 0;
        drive(1'b0, rand_vin());
        for (int seg = 0; seg < 25; seg++) begin
            if ($urandom_range(7) == 0) begin
                len = int'($urandom_range(3, 1));
                for (int k = 0; k < len; k++) drive(1'b0, rand_vin());
            end
            v   = rand_vin();
            len = int'($urandom_range(80, 20));
            for (int k = 0; k < len; k++) drive(1'b1, v);
        end
        n_total++;
        if (step_err !== 0) $display("FAIL random_model: %0d cycles differ, first at cycle %0d, required 0", step_err, first_err_cyc);
        else n_pass++;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        step_err      = 0;
        first_err_cyc = 0;
        cyc           = 0;
        m             = '0;
        reset         = 1'b0;
        vin           = '0;
        test_reset();
        test_idle();
        test_half_scale();
        test_saturation();
        test_latency();
        test_midstream_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
